// File: rtl/bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : bit_synchronizer
// Purpose  : Per-bit multi-flop synchronizer. Each bit of ASYNC passes through
//            its own chain of NUM_STAGES flops clocked by CLK, bringing
//            quasi-static or single-bit-changing control signals from a
//            foreign clock domain into the CLK domain. Bits are synchronized
//            independently; there is no bus-level coherency.
// Ports    : CLK   in   1          destination clock, rising edge
//            RST   in   1          asynchronous active-high reset, clears all
//                                  stages immediately
//            ASYNC in   BUS_WIDTH  asynchronous input bits
//            SYNC  out  BUS_WIDTH  synchronized bits (last stage of each chain)
// Revision : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int NUM_STAGES = 3,
  parameter int BUS_WIDTH  = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  output logic [BUS_WIDTH-1:0] SYNC
);

  generate
    if (NUM_STAGES < 2 || BUS_WIDTH < 1) begin : g_param_error
      // Fewer than two stages gives no metastability resolution time.
      $error("bit_synchronizer: NUM_STAGES must be >= 2 and BUS_WIDTH >= 1");
    end else begin : g_chains
      for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        // stage[0] may go metastable; the remaining stages give it time to
        // resolve. Only the last stage leaves this module. The attribute keeps
        // the chain together as synchronizer cells (no retiming/merging).
        (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] stage;

        always_ff @(posedge CLK or posedge RST) begin
          if (RST) begin
            stage <= '0;
          end else begin
            stage <= {stage[NUM_STAGES-2:0], ASYNC[i]};
          end
        end

        // Output is a flop output with no logic in between.
        assign SYNC[i] = stage[NUM_STAGES-1];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_synchronizer
// Purpose  : Self-checking bench for bit_synchronizer. Three instances
//            (3 stages x 3 bits, 2 stages x 8 bits, 4 stages x 8 bits) share
//            clock and reset. A history model predicts every output each
//            cycle; directed checks pin hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_synchronizer;

  logic       clk;
  logic       rst;
  logic [2:0] a3;
  logic [7:0] a8;
  logic [2:0] s3;
  logic [7:0] s2;
  logic [7:0] s4;

  int checks = 0;
  int errors = 0;

  bit_synchronizer #(.NUM_STAGES(3), .BUS_WIDTH(3)) dut3 (
    .CLK(clk), .RST(rst), .ASYNC(a3), .SYNC(s3)
  );
  bit_synchronizer #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
    .CLK(clk), .RST(rst), .ASYNC(a8), .SYNC(s2)
  );
  bit_synchronizer #(.NUM_STAGES(4), .BUS_WIDTH(8)) dut4 (
    .CLK(clk), .RST(rst), .ASYNC(a8), .SYNC(s4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history of values sampled at each rising edge since the last
  // reset, newest first. After an edge, an N-stage synchronizer shows the
  // value sampled N-1 edges earlier, or 0 if fewer than N edges have passed
  // since reset released.
  logic [7:0] h3[$];
  logic [7:0] h8[$];

  always @(posedge rst) begin
    h3.delete();
    h8.delete();
  end

  always @(posedge clk) begin
    if (rst) begin
      h3.delete();
      h8.delete();
    end else begin
      h3.push_front({5'b0, a3});
      h8.push_front(a8);
      if (h3.size() > 8) void'(h3.pop_back());
      if (h8.size() > 8) void'(h8.pop_back());
    end
    #1;
    chk("model_s3", {5'b0, s3}, (h3.size() >= 3) ? h3[2] : 8'h00);
    chk("model_s2", s2,         (h8.size() >= 2) ? h8[1] : 8'h00);
    chk("model_s4", s4,         (h8.size() >= 4) ? h8[3] : 8'h00);
  end

  task automatic edge_chk(input string name, input logic [7:0] exp);
    @(posedge clk);
    #1;
    chk(name, {5'b0, s3}, exp);
  endtask

  initial begin
    rst = 1'b1;
    a3  = 3'b111;
    a8  = 8'hA5;

    // Reset holds all outputs low despite active inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_s3", {5'b0, s3}, 8'h00);
      chk("reset_s2", s2, 8'h00);
      chk("reset_s4", s4, 8'h00);
    end

    // Release with a8 = A5 already applied: 2-stage sees it after 2 edges,
    // 4-stage after 4 edges.
    @(negedge clk);
    rst = 1'b0;
    a3  = 3'b000;
    @(posedge clk); #1;
    chk("sweep2_e1", s2, 8'h00);
    chk("sweep4_e1", s4, 8'h00);
    @(posedge clk); #1;
    chk("sweep2_e2", s2, 8'hA5);
    chk("sweep4_e2", s4, 8'h00);
    @(posedge clk); #1;
    chk("sweep4_e3", s4, 8'h00);
    @(posedge clk); #1;
    chk("sweep4_e4", s4, 8'hA5);

    // Latency: 000 -> 101 between edges, visible on the 3rd edge, then held.
    @(negedge clk);
    a3 = 3'b101;
    edge_chk("lat_e1", 8'h00);
    edge_chk("lat_e2", 8'h00);
    edge_chk("lat_e3", 8'h05);
    edge_chk("lat_hold1", 8'h05);
    edge_chk("lat_hold2", 8'h05);

    // Mid-operation reset asserted away from an edge clears outputs at once.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_s3", {5'b0, s3}, 8'h00);
    chk("midrst_s2", s2, 8'h00);
    chk("midrst_s4", s4, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    edge_chk("rerel_e1", 8'h00);
    edge_chk("rerel_e2", 8'h00);
    edge_chk("rerel_e3", 8'h05);

    // Only bit 1 changes; other bits stay put.
    @(negedge clk);
    a3 = 3'b111;
    edge_chk("indep_e1", 8'h05);
    edge_chk("indep_e2", 8'h05);
    edge_chk("indep_e3", 8'h07);

    // Two-period pulse on bit 0 appears as a 2-cycle pulse after 3 edges.
    @(negedge clk);
    a3 = 3'b000;
    repeat (4) @(posedge clk);
    @(negedge clk);
    a3 = 3'b001;
    @(negedge clk);
    @(negedge clk);
    a3 = 3'b000;
    // Two sampling edges have already passed; s3 still low.
    #1;
    chk("pulse_pre", {5'b0, s3}, 8'h00);
    edge_chk("pulse_e3", 8'h01);
    edge_chk("pulse_e4", 8'h01);
    edge_chk("pulse_e5", 8'h00);

    // Input change coinciding with reset release is sampled normally.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a8  = 8'h3C;
    @(posedge clk); #1;
    chk("relchg_e1", s2, 8'h00);
    @(posedge clk); #1;
    chk("relchg_e2", s2, 8'h3C);

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bit_synchronizer.md
Name: bit_synchronizer

Overview:
- Per-bit multi-flop synchronizer. Brings quasi-static or single-bit-changing control signals from another clock domain into the CLK domain.
- Each bit of ASYNC passes through an independent chain of NUM_STAGES flip-flops clocked by CLK.
- Sits at clock-domain-crossing boundaries, e.g. enables, flags and pulse-stretched requests entering the system clock domain.

Parameters:
- NUM_STAGES, 3: number of flip-flops in each bit's chain; legal range 2..8.
- BUS_WIDTH, 3: number of independent bits synchronized; legal range >= 1.

Ports:
- CLK  input  1  destination-domain clock; all flops update on the rising edge.
- RST  input  1  asynchronous, active-high reset; clears every stage.
- ASYNC  input  BUS_WIDTH  asynchronous input bits from a foreign domain.
- SYNC  output  BUS_WIDTH  synchronized bits; the last stage of each chain.

Behaviour:
- Interface decision: one clock (CLK); reset RST is asynchronous and active-high.
- Reset:
  - While RST=1, every stage flop of every bit is forced to 0 immediately, without waiting for a CLK edge.
  - SYNC=0 throughout reset.
  - After RST deasserts, the chains capture normally from the next CLK rising edge.
- Per-bit chain, on each rising CLK edge with RST=0:
  - stage[0] <= ASYNC[i].
  - stage[k] <= stage[k-1] for k = 1..NUM_STAGES-1.
  - SYNC[i] = stage[NUM_STAGES-1], driven directly by a flop with no combinational logic on the output.
- Latency:
  - A level on ASYNC that is stable across the sampling edge appears on SYNC after exactly NUM_STAGES rising edges, counting the sampling edge as edge 1.
  - With the default of 3 stages and a 10 ns clock, SYNC changes 20 ns after the sampling edge.
- Bit independence:
  - Bits are not coherent with each other. Multi-bit values are only safe if quasi-static or Gray-coded.
  - No bus-level consistency logic is provided.
- Pulse handling:
  - An ASYNC pulse shorter than one CLK period may be lost. This is legal behaviour.
  - A pulse of at least one period plus setup/hold always appears on SYNC with its width rounded to whole cycles.
- Metastability: stage[0] may go metastable; later stages are its resolution time. No logic may read stage[0..NUM_STAGES-2] outside the block.
- Reset mid-operation: all in-flight values are discarded and SYNC goes to 0 at once. Values are re-captured only after RST deasserts.
- Simultaneous ASYNC change and RST deassertion: the first edge after release samples ASYNC normally. There are no spurious glitches on SYNC.
- Parameter checks: elaboration-time error if NUM_STAGES < 2 or BUS_WIDTH < 1.
- Synthesis: the flops are attributed/constrained as synchronizer cells (ASYNC_REG or equivalent) and are not to be retimed or merged.

Test Plan:
- Reset value: RST=1 with ASYNC=3'b111 and a toggling clock -> SYNC stays 3'b000 for the whole reset period.
- Latency: RST deasserted, ASYNC=3'b000 then ASYNC=3'b101 set between edges with a 10 ns clock -> SYNC=3'b000 for the first 2 edges after the change and 3'b101 on the 3rd rising edge. SYNC then holds 3'b101.
- Mid-operation async reset: ASYNC=3'b101 propagated so SYNC=3'b101; assert RST away from a clock edge -> SYNC=3'b000 immediately. After release with ASYNC still 3'b101, SYNC returns to 3'b101 on the 3rd edge.
- Per-bit independence: change only ASYNC[1] from 0 to 1 -> only SYNC[1] changes, after 3 edges; SYNC[0] and SYNC[2] are unaffected.
- Parameter sweep: NUM_STAGES=2 and BUS_WIDTH=8 with ASYNC=8'hA5 -> SYNC=8'hA5 after exactly 2 edges. Repeat with NUM_STAGES=4, giving 4 edges.
- Short pulse: ASYNC held for exactly 2 clock periods -> SYNC shows a 2-cycle pulse delayed by NUM_STAGES edges, then returns to 0.
